// File: rtl/rgb_pwm_driver_if.sv
// rtl/rgb_pwm_driver_if.sv - duty write port into the rgb_pwm_driver shadow bank
//
// Ports (signals):
//   wr_valid  master->slave  duty write request
//   wr_ready  slave->master  driver can accept a write (low while a frame awaits commit)
//   wr_chan   master->slave  channel index
//   wr_duty   master->slave  duty value for wr_chan
//   wr_last   master->slave  write closes a frame; request commit
interface rgb_pwm_driver_if #(
  parameter int DUTY_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_chan;
  logic [DUTY_W-1:0] wr_duty;
  logic              wr_last;

  modport master (
    output wr_valid, wr_chan, wr_duty, wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_chan, wr_duty, wr_last,
    output wr_ready
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - per-channel 8-bit PWM driver for the active-low RGB LED pins
//
// Duty writes land in a shadow bank; a frame closed with wr_last is copied to the
// active bank only at a PWM period boundary, so a frame never tears mid-period.
// Optional macro RGB_PWM_PHASE_STAGGER_EN: offsets each channel's compare phase by
// i*floor(2^DUTY_W/CHANNELS) ticks to spread turn-on edges across the period.
//
// Ports:
//   clk100        in   system clock
//   rst_n         in   asynchronous active-low reset
//   wr            slave modport of rgb_pwm_driver_if (valid/ready duty writes)
//   pending       out  committed frame waiting for a period boundary
//   period_start  out  one-cycle pulse in the first cycle with pwm_cnt == 0
//   leds_n        out  active-low PWM outputs, bit i drives channel i
module rgb_pwm_driver #(
  parameter int CHANNELS = 12,
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 390
) (
  input  logic                clk100,
  input  logic                rst_n,
  rgb_pwm_driver_if.slave     wr,
  output logic                pending,
  output logic                period_start,
  output logic [CHANNELS-1:0] leds_n
);

  localparam int                PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST = '1;
`ifdef RGB_PWM_PHASE_STAGGER_EN
  localparam int                STAGGER  = (1 << DUTY_W) / CHANNELS;
`endif

  logic [PS_W-1:0]   ps_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] shadow [CHANNELS];
  logic [DUTY_W-1:0] active [CHANNELS];
  logic [DUTY_W-1:0] cmp_cnt [CHANNELS];
  logic              tick;
  logic              boundary;
  logic              accept;

  assign tick        = (ps_cnt == PS_LAST);
  assign boundary    = tick && (pwm_cnt == CNT_LAST);
  // While a frame waits for its boundary the shadow bank is frozen.
  assign wr.wr_ready = ~pending;
  assign accept      = wr.wr_valid && !pending;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef RGB_PWM_PHASE_STAGGER_EN
      // Modulo-2^DUTY_W wrap of the addition gives the phase rotation for free.
      cmp_cnt[i] = pwm_cnt + DUTY_W'(i * STAGGER);
`else
      cmp_cnt[i] = pwm_cnt;
`endif
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt       <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
      pending      <= 1'b0;
      leds_n       <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      period_start <= boundary;

      // Compare against the current active bank; a commit on this same edge is
      // seen one cycle later, i.e. from pwm_cnt == 0 of the new period.
      for (int i = 0; i < CHANNELS; i++) begin
        leds_n[i] <= ~(active[i] > cmp_cnt[i]);
      end

      // Out-of-range channels match no shadow slot but still honour wr_last.
      if (accept) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (int'(wr.wr_chan) == i) begin
            shadow[i] <= wr.wr_duty;
          end
        end
        if (wr.wr_last) begin
          pending <= 1'b1;
        end
      end

      // accept needs pending == 0, so it never coincides with a commit; a frame
      // accepted on a boundary cycle waits for the next one.
      if (boundary && pending) begin
        for (int i = 0; i < CHANNELS; i++) begin
          active[i] <= shadow[i];
        end
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - scoreboard bench for rgb_pwm_driver
module tb_rgb_pwm_driver;

  localparam int CH  = 12;
  localparam int PS  = 2;
  localparam int PER = 256 * PS;

  logic          clk100 = 1'b0;
  logic          rst_n  = 1'b0;
  logic          pending;
  logic          period_start;
  logic [CH-1:0] leds_n;

  rgb_pwm_driver_if #(.DUTY_W(8)) wr_if ();

  rgb_pwm_driver #(
    .CHANNELS(CH),
    .DUTY_W  (8),
    .PRESCALE(PS)
  ) dut (
    .clk100      (clk100),
    .rst_n       (rst_n),
    .wr          (wr_if.slave),
    .pending     (pending),
    .period_start(period_start),
    .leds_n      (leds_n)
  );

  always #5 clk100 = ~clk100;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]     period;
    logic [CH*8-1:0] duty;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] shadow_m [CH];
  logic [7:0] cur_exp  [CH];
  logic [7:0] win_exp  [CH];
  int         low_cnt  [CH];
  int         last_low [CH];
  int         win_start;
  bit         win_on;
  int         cyc;

  // Edges counted since reset release; period k starts at cyc == k*PER.
  always @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Measures each period window [k*PER, (k+1)*PER) and compares per-channel
  // low time and last low offset against the duties expected for that period.
  initial begin
    sb_t e;
    win_on = 1'b0;
    forever begin
      @(negedge clk100);
      if (!rst_n) begin
        win_on = 1'b0;
        for (int c = 0; c < CH; c++) cur_exp[c] = 8'd0;
      end else begin
        if (period_start || (cyc > 0 && cyc % PER == 0))
          chk("pstart_align", {31'd0, period_start}, {31'd0, (cyc > 0 && cyc % PER == 0)});
        if (period_start) begin
          if (win_on) begin
            for (int c = 0; c < CH; c++) begin
              chk($sformatf("low_cnt ch%0d p%0d", c, win_start / PER), low_cnt[c], PS * int'(win_exp[c]));
`ifndef RGB_PWM_PHASE_STAGGER_EN
              chk($sformatf("low_end ch%0d p%0d", c, win_start / PER), last_low[c], PS * int'(win_exp[c]));
`endif
            end
          end
          while (sb_q.size() > 0 && int'(sb_q[0].period) <= cyc / PER) begin
            e = sb_q.pop_front();
            for (int c = 0; c < CH; c++) cur_exp[c] = e.duty[c*8 +: 8];
          end
          for (int c = 0; c < CH; c++) begin
            win_exp[c]  = cur_exp[c];
            low_cnt[c]  = 0;
            last_low[c] = 0;
          end
          win_start = cyc;
          win_on    = 1'b1;
        end
        if (win_on) begin
          for (int c = 0; c < CH; c++) begin
            if (leds_n[c] == 1'b0) begin
              low_cnt[c]++;
              last_low[c] = cyc - win_start;
            end
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc < t && n < 20000) begin
      @(posedge clk100); #1;
      n++;
    end
    if (cyc < t) chk("wait_cyc_timeout", cyc, t);
  endtask

  task automatic wait_pstart();
    int n = 0;
    do begin
      @(negedge clk100);
      n++;
    end while (!period_start && n < PER + 16);
    chk("pstart_timeout", {31'd0, period_start}, 32'd1);
  endtask

  // Drives one write, holds it until accepted, pushes the expected frame.
  task automatic drive_write(input int ch, input int duty, input bit last,
                             output int e, output int k);
    int  n = 0;
    sb_t s;
    @(posedge clk100); #1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_chan  = ch[3:0];
    wr_if.wr_duty  = duty[7:0];
    wr_if.wr_last  = last;
    while (wr_if.wr_ready !== 1'b1 && n < 2 * PER) begin
      @(posedge clk100); #1;
      n++;
    end
    if (n >= 2 * PER) chk("wr_ready_timeout", {31'd0, wr_if.wr_ready}, 32'd1);
    @(posedge clk100); #1;
    e = cyc;
    k = e / PER + 1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    if (ch < CH) shadow_m[ch] = duty[7:0];
    chk("pend_after_accept", {31'd0, pending}, {31'd0, last});
    if (last) begin
      s.period = k;
      for (int c = 0; c < CH; c++) s.duty[c*8 +: 8] = shadow_m[c];
      sb_q.push_back(s);
    end
  endtask

  task automatic wait_commit(input int k);
    wait_cyc(PER * k - 1);
    chk("pend_before_commit", {31'd0, pending}, 32'd1);
    @(posedge clk100); #1;
    chk("pend_clear_commit", {31'd0, pending}, 32'd0);
  endtask

  initial begin
    int e, k, k1, m;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_chan  = 4'd0;
    wr_if.wr_duty  = 8'd0;
    wr_if.wr_last  = 1'b0;
    for (int c = 0; c < CH; c++) shadow_m[c] = 8'd0;

    // Reset state
    repeat (3) @(negedge clk100);
    chk("rst_leds", {20'd0, leds_n}, 32'hFFF);
    chk("rst_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_pstart", {31'd0, period_start}, 32'd0);
    rst_n = 1'b1;
    wait_pstart();
    chk("first_pstart_cyc", cyc, PER);

    // Half duty on ch0
    drive_write(0, 128, 1'b1, e, k);
    wait_commit(k);
    wait_cyc(PER * (k + 2) + 2);

    // Tear-free: ch3 alone stays invisible until ch4 closes the frame
    wait_cyc(cyc + 100);
    drive_write(3, 10, 1'b0, e, k);
    wait_cyc(PER * (cyc / PER + 2) + 5);
    drive_write(4, 200, 1'b1, e, k);
    wait_commit(k);
    wait_cyc(PER * (k + 1) + 2);

    // Backpressure: second write held until the cycle after pending drops
    drive_write(6, 30, 1'b1, e, k1);
    chk("bp_ready_low", {31'd0, wr_if.wr_ready}, 32'd0);
    drive_write(5, 50, 1'b1, e, k);
    chk("bp_accept_cyc", e, PER * k1 + 1);
    wait_commit(k);
    wait_cyc(PER * (k + 1) + 2);

    // Duty 255
    drive_write(2, 255, 1'b1, e, k);
    wait_commit(k);
    wait_cyc(PER * (k + 1) + 2);

    // Out-of-range channel: no duty change, pending still pulses
    drive_write(13, 99, 1'b1, e, k);
    wait_commit(k);
    wait_cyc(PER * (k + 1) + 2);

    // Accept exactly on a boundary edge: commit slips one period
    m = cyc / PER + 1;
    wait_cyc(PER * m - 2);
    drive_write(7, 77, 1'b1, e, k);
    chk("simul_accept_cyc", e, PER * m);
    wait_commit(m + 1);
    wait_cyc(PER * (m + 2) + 2);

    // Reset mid-frame
    drive_write(1, 100, 1'b1, e, k);
    wait_commit(k);
    wait_cyc(PER * k + 20);
    chk("rm_ch1_lit", {31'd0, leds_n[1]}, 32'd0);
    drive_write(8, 5, 1'b1, e, k);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rm_leds_off", {20'd0, leds_n}, 32'hFFF);
    chk("rm_pending", {31'd0, pending}, 32'd0);
    sb_q.delete();
    for (int c = 0; c < CH; c++) shadow_m[c] = 8'd0;
    repeat (3) @(negedge clk100);
    rst_n = 1'b1;
    wait_cyc(PER * 3 + 2);
    chk("rm_pending_after", {31'd0, pending}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
